// File: rtl/uart_tx_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | uart_tx_pkg : shared types and helpers for the UART transmit framer      |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
package uart_tx_pkg;

  localparam int MAX_WIDTH = 9;

  localparam logic PAR_EVEN = 1'b0;
  localparam logic PAR_ODD  = 1'b1;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    ARM    = 3'd1,
    START  = 3'd2,
    DATA   = 3'd3,
    PARITY = 3'd4,
    STOP1  = 3'd5,
    STOP2  = 3'd6
  } state_t;

  // Zero-extension to MAX_WIDTH leaves the XOR reduction unchanged.
  function automatic logic calc_parity(input logic [MAX_WIDTH-1:0] data, input logic typ);
    return (typ == PAR_ODD) ? ~(^data) : (^data);
  endfunction

endpackage
`default_nettype wire

// File: rtl/uart_tx_shift.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | uart_tx_shift : payload shift register with bit counter and last flag    |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module uart_tx_shift #(
  parameter int DATA_WIDTH = 8,
  parameter bit LSB_FIRST  = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load,
  input  logic                  shift,
  input  logic [DATA_WIDTH-1:0] data_in,
  output logic                  ser_bit,
  output logic                  next_bit,
  output logic                  last_bit
);

  localparam int CNT_W = $clog2(DATA_WIDTH);

  logic [DATA_WIDTH-1:0] sreg;
  logic [DATA_WIDTH-1:0] shifted;
  logic [CNT_W-1:0]      bit_cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sreg    <= '0;
      bit_cnt <= '0;
    end else if (load) begin
      sreg    <= data_in;
      bit_cnt <= '0;
    end else if (shift) begin
      sreg    <= shifted;
      bit_cnt <= bit_cnt + 1'b1;
    end
  end

  // next_bit lets the framer register the following bit on the same edge it shifts.
  generate
    if (LSB_FIRST) begin : g_lsb_first
      assign ser_bit  = sreg[0];
      assign next_bit = sreg[1];
      assign shifted  = {1'b0, sreg[DATA_WIDTH-1:1]};
    end else begin : g_msb_first
      assign ser_bit  = sreg[DATA_WIDTH-1];
      assign next_bit = sreg[DATA_WIDTH-2];
      assign shifted  = {sreg[DATA_WIDTH-2:0], 1'b0};
    end
  endgenerate

  assign last_bit = (bit_cnt == CNT_W'(DATA_WIDTH - 1));

endmodule
`default_nettype wire

// File: rtl/uart_tx_frame.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | uart_tx_frame : tick-paced UART framer (start/data/parity/stop)          |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module uart_tx_frame
  import uart_tx_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter bit LSB_FIRST  = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  bit_tick,
  input  logic [DATA_WIDTH-1:0] p_data,
  input  logic                  data_valid,
  input  logic                  par_en,
  input  logic                  par_typ,
  input  logic                  stop2,
  output logic                  data_ack,
  output logic                  busy,
  output logic                  tx_out
);

  state_t state, state_nxt;
  logic   tx_nxt, capture, shift_en, frame_end;
  logic   cfg_par_en, cfg_stop2, par_bit;
  logic   ser_bit, next_bit, last_bit;

  uart_tx_shift #(
    .DATA_WIDTH(DATA_WIDTH),
    .LSB_FIRST (LSB_FIRST)
  ) u_shift (
    .clk     (clk),
    .rst     (rst),
    .load    (capture),
    .shift   (shift_en),
    .data_in (p_data),
    .ser_bit (ser_bit),
    .next_bit(next_bit),
    .last_bit(last_bit)
  );

  // Parity is resolved at capture so par_typ need not be kept separately.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      tx_out     <= 1'b1;
      data_ack   <= 1'b0;
      cfg_par_en <= 1'b0;
      cfg_stop2  <= 1'b0;
      par_bit    <= 1'b0;
    end else begin
      state    <= state_nxt;
      tx_out   <= tx_nxt;
      data_ack <= capture;
      if (capture) begin
        cfg_par_en <= par_en;
        cfg_stop2  <= stop2;
        par_bit    <= calc_parity(MAX_WIDTH'(p_data), par_typ);
      end
    end
  end

  always_comb begin
    state_nxt = state;
    tx_nxt    = tx_out;
    capture   = 1'b0;
    shift_en  = 1'b0;
    frame_end = 1'b0;
    case (state)
      IDLE: begin
        if (data_valid) begin
          capture   = 1'b1;
          state_nxt = ARM;
        end
      end
      ARM: begin
        if (bit_tick) begin
          state_nxt = START;
          tx_nxt    = 1'b0;
        end
      end
      START: begin
        if (bit_tick) begin
          state_nxt = DATA;
          tx_nxt    = ser_bit;
        end
      end
      DATA: begin
        if (bit_tick) begin
          if (!last_bit) begin
            shift_en = 1'b1;
            tx_nxt   = next_bit;
          end else if (cfg_par_en) begin
            state_nxt = PARITY;
            tx_nxt    = par_bit;
          end else begin
            state_nxt = STOP1;
            tx_nxt    = 1'b1;
          end
        end
      end
      PARITY: begin
        if (bit_tick) begin
          state_nxt = STOP1;
          tx_nxt    = 1'b1;
        end
      end
      STOP1: begin
        if (bit_tick) begin
          if (cfg_stop2) state_nxt = STOP2;
          else           frame_end = 1'b1;
        end
      end
      STOP2: begin
        if (bit_tick) frame_end = 1'b1;
      end
      default: begin
        state_nxt = IDLE;
        tx_nxt    = 1'b1;
      end
    endcase

    // A word waiting at end of frame starts immediately, with no idle bit.
    if (frame_end) begin
      if (data_valid) begin
        capture   = 1'b1;
        state_nxt = START;
        tx_nxt    = 1'b0;
      end else begin
        state_nxt = IDLE;
        tx_nxt    = 1'b1;
      end
    end
  end

  assign busy = (state != IDLE);

endmodule
`default_nettype wire
